periodic_finish_timer: RTL and testbench

Synthesizable period/finish timer for self-checking regression benches. It emits a one-cycle `tick` every PERIOD clocks while running. After LIMIT ticks it asserts `done` with a pass/fail verdict, which is the cycle-accurate equivalent of a free-running delay loop paired with a timed finish. It sits directly upstream of the bench's reporting stage: that stage consumes `done`/`passed`, prints the PASSED/FAILED line and ends the run, then returns `done_ack`.

---
 rtl/periodic_finish_timer.sv | 147 ++++++++++++++
 tb/tb_periodic_finish_timer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periodic_finish_timer.sv
// -----------------------------------------------------------------------------
// periodic_finish_timer
//
// Cycle-accurate period/finish timer for self-checking benches. While a run is
// active it pulses `tick` once every PERIOD clocks. After LIMIT ticks it enters
// DONE and reports a pass/fail verdict. The verdict is a fail if a checker
// error was seen or if the run was aborted. The reporting stage releases DONE
// with `done_ack`.
//
// Parameters:
//   PERIOD      clocks between ticks (>= 1)
//   LIMIT       ticks before finish (1 <= LIMIT < 2**CW)
//   CW          width of the tick counter
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a run (sampled in IDLE only)
//   abort       end the run as failed (sampled in RUN only)
//   error       checker error strobe, sticky (sampled in RUN only)
//   done_ack    consumer acknowledge of done (sampled in DONE only)
//   tick        one-cycle pulse per elapsed period
//   tick_count  completed ticks in the current or just-finished run
//   busy        high while running
//   done        high throughout DONE
//   passed      verdict, valid only while done = 1 (0 otherwise)
// -----------------------------------------------------------------------------
module periodic_finish_timer #(
  parameter int PERIOD = 10,
  parameter int LIMIT  = 2,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          error,
  input  logic          done_ack,
  output logic          tick,
  output logic [CW-1:0] tick_count,
  output logic          busy,
  output logic          done,
  output logic          passed
);

  // The cycle counter needs at least one bit, even when PERIOD = 1.
  localparam int CYC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PERIOD - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             period_end;

  // The last cycle of a period while running. This is the cycle that would
  // carry a tick unless abort arrives at the same time.
  assign period_end = (state_q == S_RUN) && (cyc_q == CYC_LAST);

  // NOTE: every signal written here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    aborted_d = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        // All counters are already zero in IDLE, so the run starts at cyc = 0.
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        // The error flag is sticky and also catches a strobe on the final-tick
        // or abort cycle.
        if (error) err_d = 1'b1;

        if (abort) begin
          // Abort wins over the final tick: the counters freeze where they are.
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (period_end) begin
          cyc_d = '0;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_DONE: begin
        // A start in the same cycle as done_ack is ignored. The next start is
        // taken from IDLE one cycle later.
        if (done_ack) begin
          state_d   = S_IDLE;
          cyc_d     = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
          aborted_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cyc_d     = '0;
        cnt_d     = '0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign tick       = period_end && !abort;
  assign tick_count = cnt_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign passed     = (state_q == S_DONE) && !err_q && !aborted_q;

endmodule

// File: tb/tb_periodic_finish_timer.sv
// -----------------------------------------------------------------------------
// tb_periodic_finish_timer
//
// Bench for periodic_finish_timer. It uses two instances: the default
// configuration (PERIOD=10, LIMIT=2) and a PERIOD=1, LIMIT=3, CW=2 variant.
//
// Each table row holds one input pattern, a repeat count and the outputs
// expected during each of those cycles. The driver applies inputs just after
// the rising edge and pushes the expectation onto a scoreboard queue. The
// monitor pops the queue on the falling edge and compares. A hand-written
// sequence then measures the start-to-done latency with a bounded wait.
// -----------------------------------------------------------------------------
module tb_periodic_finish_timer;

  // Input pattern bits: {reset, start, abort, error, done_ack}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_RST  = 5'b10000;
  localparam logic [4:0] I_STA  = 5'b01000;
  localparam logic [4:0] I_ABT  = 5'b00100;
  localparam logic [4:0] I_ERR  = 5'b00010;
  localparam logic [4:0] I_ACK  = 5'b00001;

  // Output pattern bits: {tick, busy, done, passed}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_RUN  = 4'b0100;
  localparam logic [3:0] O_TICK = 4'b1100;
  localparam logic [3:0] O_PASS = 4'b0011;
  localparam logic [3:0] O_FAIL = 4'b0010;

  typedef struct {
    int         dut;
    int         n;
    logic [4:0] in;
    logic [3:0] out;
    int         cnt;
  } vec_t;

  typedef struct {
    int         dut;
    int         idx;
    logic [3:0] out;
    int         cnt;
  } exp_t;

  logic clk;

  // Default instance
  logic       reset, start, abort, error, done_ack;
  logic       tick, busy, done, passed;
  logic [7:0] tick_count;

  // PERIOD=1 instance
  logic       p1_reset, p1_start, p1_abort, p1_error, p1_done_ack;
  logic       p1_tick, p1_busy, p1_done, p1_passed;
  logic [1:0] p1_tick_count;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  exp_t sb[$];

  periodic_finish_timer #(.PERIOD(10), .LIMIT(2), .CW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .error      (error),
    .done_ack   (done_ack),
    .tick       (tick),
    .tick_count (tick_count),
    .busy       (busy),
    .done       (done),
    .passed     (passed)
  );

  periodic_finish_timer #(.PERIOD(1), .LIMIT(3), .CW(2)) dut_p1 (
    .clk        (clk),
    .reset      (p1_reset),
    .start      (p1_start),
    .abort      (p1_abort),
    .error      (p1_error),
    .done_ack   (p1_done_ack),
    .tick       (p1_tick),
    .tick_count (p1_tick_count),
    .busy       (p1_busy),
    .done       (p1_done),
    .passed     (p1_passed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input int n, input logic [4:0] in,
                              input logic [3:0] out, input int cnt);
    vec_t v;
    v.dut = dut;
    v.n   = n;
    v.in  = in;
    v.out = out;
    v.cnt = cnt;
    return v;
  endfunction

  // Apply one table row for v.n cycles. Inputs change just after a rising
  // edge, and the expected outputs for that cycle go onto the scoreboard.
  task automatic apply(input int idx);
    vec_t v;
    exp_t e;
    v = vecs[idx];
    for (int r = 0; r < v.n; r++) begin
      if (v.dut == 0) begin
        {reset, start, abort, error, done_ack} = v.in;
        {p1_reset, p1_start, p1_abort, p1_error, p1_done_ack} = 5'b00000;
      end else begin
        {reset, start, abort, error, done_ack} = 5'b00000;
        {p1_reset, p1_start, p1_abort, p1_error, p1_done_ack} = v.in;
      end
      e.dut = v.dut;
      e.idx = idx;
      e.out = v.out;
      e.cnt = v.cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare in mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [3:0] act;
      int         act_cnt;
      e = sb.pop_front();
      if (e.dut == 0) begin
        act     = {tick, busy, done, passed};
        act_cnt = int'(tick_count);
      end else begin
        act     = {p1_tick, p1_busy, p1_done, p1_passed};
        act_cnt = int'(p1_tick_count);
      end
      check($sformatf("v%0d.tick", e.idx),       int'(act[3]), int'(e.out[3]));
      check($sformatf("v%0d.busy", e.idx),       int'(act[2]), int'(e.out[2]));
      check($sformatf("v%0d.done", e.idx),       int'(act[1]), int'(e.out[1]));
      check($sformatf("v%0d.passed", e.idx),     int'(act[0]), int'(e.out[0]));
      check($sformatf("v%0d.tick_count", e.idx), act_cnt,      e.cnt);
    end
  end

  initial begin : main
    int n;

    {reset, start, abort, error, done_ack} = 5'b10000;
    {p1_reset, p1_start, p1_abort, p1_error, p1_done_ack} = 5'b10000;
    repeat (2) @(posedge clk);
    #1;

    // ---- Reset state ----
    vecs.push_back(mk(0, 1, I_RST,  O_IDLE, 0));
    vecs.push_back(mk(0, 2, I_NONE, O_IDLE, 0));

    // ---- Normal run, then done_ack held low for 5 cycles ----
    vecs.push_back(mk(0, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  1));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 1));
    vecs.push_back(mk(0, 5, I_NONE, O_PASS, 2));
    vecs.push_back(mk(0, 1, I_ACK,  O_PASS, 2));
    vecs.push_back(mk(0, 1, I_NONE, O_IDLE, 0));

    // ---- Error on third RUN cycle; ack together with start ----
    vecs.push_back(mk(0, 1, I_STA,         O_IDLE, 0));
    vecs.push_back(mk(0, 2, I_NONE,        O_RUN,  0));
    vecs.push_back(mk(0, 1, I_ERR,         O_RUN,  0));
    vecs.push_back(mk(0, 6, I_NONE,        O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE,        O_TICK, 0));
    vecs.push_back(mk(0, 9, I_NONE,        O_RUN,  1));
    vecs.push_back(mk(0, 1, I_NONE,        O_TICK, 1));
    vecs.push_back(mk(0, 1, I_NONE,        O_FAIL, 2));
    vecs.push_back(mk(0, 1, I_ACK | I_STA, O_FAIL, 2));
    vecs.push_back(mk(0, 1, I_STA,         O_IDLE, 0));

    // ---- Error on the final-tick cycle ----
    vecs.push_back(mk(0, 9, I_NONE,        O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE,        O_TICK, 0));
    vecs.push_back(mk(0, 9, I_NONE,        O_RUN,  1));
    vecs.push_back(mk(0, 1, I_ERR,         O_TICK, 1));
    vecs.push_back(mk(0, 1, I_ACK,         O_FAIL, 2));
    vecs.push_back(mk(0, 1, I_ABT | I_ERR, O_IDLE, 0));

    // ---- Abort sampled at N+7 ----
    vecs.push_back(mk(0, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(0, 6, I_NONE, O_RUN,  0));
    vecs.push_back(mk(0, 1, I_ABT,  O_RUN,  0));
    vecs.push_back(mk(0, 2, I_NONE, O_FAIL, 0));
    vecs.push_back(mk(0, 1, I_ACK,  O_FAIL, 0));

    // ---- Abort in the final-tick cycle ----
    vecs.push_back(mk(0, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  1));
    vecs.push_back(mk(0, 1, I_ABT,  O_RUN,  1));
    vecs.push_back(mk(0, 1, I_ERR,  O_FAIL, 1));
    vecs.push_back(mk(0, 1, I_ACK,  O_FAIL, 1));

    // ---- Reset at N+12, then a clean full run (start held in RUN) ----
    vecs.push_back(mk(0, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(0, 1, I_NONE, O_RUN,  1));
    vecs.push_back(mk(0, 1, I_RST,  O_RUN,  1));
    vecs.push_back(mk(0, 3, I_NONE, O_IDLE, 0));
    vecs.push_back(mk(0, 1, I_ACK,  O_IDLE, 0));
    vecs.push_back(mk(0, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(0, 9, I_STA,  O_RUN,  0));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(0, 9, I_NONE, O_RUN,  1));
    vecs.push_back(mk(0, 1, I_NONE, O_TICK, 1));
    vecs.push_back(mk(0, 1, I_NONE, O_PASS, 2));
    vecs.push_back(mk(0, 1, I_ACK,  O_PASS, 2));
    vecs.push_back(mk(0, 1, I_NONE, O_IDLE, 0));

    // ---- PERIOD=1, LIMIT=3: three consecutive ticks, then abort case ----
    vecs.push_back(mk(1, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(1, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(1, 1, I_NONE, O_TICK, 1));
    vecs.push_back(mk(1, 1, I_NONE, O_TICK, 2));
    vecs.push_back(mk(1, 2, I_NONE, O_PASS, 3));
    vecs.push_back(mk(1, 1, I_ACK,  O_PASS, 3));
    vecs.push_back(mk(1, 1, I_STA,  O_IDLE, 0));
    vecs.push_back(mk(1, 1, I_NONE, O_TICK, 0));
    vecs.push_back(mk(1, 1, I_ABT,  O_RUN,  1));
    vecs.push_back(mk(1, 1, I_ACK,  O_FAIL, 1));
    vecs.push_back(mk(1, 1, I_NONE, O_IDLE, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // ---- Hand-written: start-to-done latency with a bounded wait ----
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_start_to_done", n, 20);
    check("latency_tick_count", int'(tick_count), 2);
    check("latency_passed", int'(passed), 1);
    check("latency_busy_low", int'(busy), 0);
    done_ack = 1'b1;
    @(posedge clk);
    #1;
    done_ack = 1'b0;
    check("ack_done_low", int'(done), 0);
    check("ack_passed_low", int'(passed), 0);
    check("ack_count_cleared", int'(tick_count), 0);

    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
